// File: rtl/sprite_layer_renderer.sv
// Sprite layer renderer: double-buffered position/control registers, a
// rectangle hit test on the incoming VGA coordinate, an address to an
// external synchronous sprite ROM, and a three-stage output with colour-key
// transparency. One instance feeds one RGB layer input of the composer.
module sprite_layer_renderer #(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
    parameter int          COORD_W   = 10,
    parameter int          MEM_AW    = $clog2(SPRITE_W * SPRITE_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mw_i,
    input  logic [31:0]        address_i,
    input  logic [31:0]        data_i,
    input  logic [COORD_W-1:0] vga_x_i,
    input  logic [COORD_W-1:0] vga_y_i,
    input  logic               pixel_valid_i,
    output logic [MEM_AW-1:0]  mem_address_o,
    input  logic [23:0]        mem_data_i,
    output logic [23:0]        rgb_data_o,
    output logic               hit_o,
    output logic               rgb_valid_o
);

    // One extra bit on every coordinate so POS + size never wraps.
    localparam int XW      = COORD_W + 1;
    localparam int COL_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int WIDE_AW = XW + COL_W;

    localparam logic [31:0] ADDR_POS_X = BASE_ADDR;
    localparam logic [31:0] ADDR_POS_Y = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + 32'h8;

    // Shadow (bus-written) and active (frame-committed) registers
    logic [COORD_W-1:0] sh_pos_x_q, sh_pos_x_d, act_pos_x_q, act_pos_x_d;
    logic [COORD_W-1:0] sh_pos_y_q, sh_pos_y_d, act_pos_y_q, act_pos_y_d;
    logic               sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic               sh_flip_q, sh_flip_d, act_flip_q, act_flip_d;

    // Pipeline state
    logic [MEM_AW-1:0]  mem_address_q, mem_address_d;
    logic               s1_hit_q, s1_valid_q;
    logic               s2_hit_q, s2_valid_q;
    logic [23:0]        rgb_data_q, rgb_data_d;
    logic               hit_q, hit_d;
    logic               rgb_valid_q;

    // Stage-0 combinational signals
    logic               frame_start;
    logic [COORD_W-1:0] eff_pos_x, eff_pos_y;
    logic               eff_en, eff_flip;
    logic [XW-1:0]      x_ext, y_ext, px_ext, py_ext, dx, dy;
    logic               in_rect;
    logic [COL_W-1:0]   col;
    logic [WIDE_AW-1:0] addr_wide;

    // Bits that are deliberately not consumed by any logic.
    logic unused_bits;
    assign unused_bits = ^{data_i[31:COORD_W], dx[XW-1:COL_W], addr_wide[WIDE_AW-1:MEM_AW]};

    assign frame_start = pixel_valid_i && (vga_x_i == '0) && (vga_y_i == '0);

    // Hit test and ROM address for the pixel being sampled this cycle
    always_comb begin
        // The frame-start pixel already uses the values being committed on this edge.
        eff_pos_x = frame_start ? sh_pos_x_q : act_pos_x_q;
        eff_pos_y = frame_start ? sh_pos_y_q : act_pos_y_q;
        eff_en    = frame_start ? sh_en_q    : act_en_q;
        eff_flip  = frame_start ? sh_flip_q  : act_flip_q;

        x_ext  = {1'b0, vga_x_i};
        y_ext  = {1'b0, vga_y_i};
        px_ext = {1'b0, eff_pos_x};
        py_ext = {1'b0, eff_pos_y};
        dx     = x_ext - px_ext;
        dy     = y_ext - py_ext;

        in_rect = eff_en && pixel_valid_i
               && (x_ext >= px_ext) && (x_ext < px_ext + XW'(SPRITE_W))
               && (y_ext >= py_ext) && (y_ext < py_ext + XW'(SPRITE_H));

        // SPRITE_W is a power of two, so SPRITE_W-1-dx is the bitwise inverse of dx.
        col       = eff_flip ? ~dx[COL_W-1:0] : dx[COL_W-1:0];
        addr_wide = (WIDE_AW'(dy) << COL_W) | WIDE_AW'(col);
    end

    // Next-state for bus registers, frame commit, ROM address and output stage
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        sh_pos_x_d    = sh_pos_x_q;
        sh_pos_y_d    = sh_pos_y_q;
        sh_en_d       = sh_en_q;
        sh_flip_d     = sh_flip_q;
        act_pos_x_d   = act_pos_x_q;
        act_pos_y_d   = act_pos_y_q;
        act_en_d      = act_en_q;
        act_flip_d    = act_flip_q;
        mem_address_d = mem_address_q;

        if (mw_i) begin
            if (address_i == ADDR_POS_X) sh_pos_x_d = data_i[COORD_W-1:0];
            if (address_i == ADDR_POS_Y) sh_pos_y_d = data_i[COORD_W-1:0];
            if (address_i == ADDR_CTRL) begin
                sh_en_d   = data_i[0];
                sh_flip_d = data_i[1];
            end
        end

        // Commit takes the pre-write shadow; a same-edge write waits a frame.
        if (frame_start) begin
            act_pos_x_d = sh_pos_x_q;
            act_pos_y_d = sh_pos_y_q;
            act_en_d    = sh_en_q;
            act_flip_d  = sh_flip_q;
        end

        if (in_rect) mem_address_d = addr_wide[MEM_AW-1:0];

        hit_d      = s2_hit_q && (mem_data_i != KEY_COLOR);
        rgb_data_d = hit_d ? mem_data_i : 24'h000000;
    end

    // All state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            sh_pos_x_q    <= '0;
            sh_pos_y_q    <= '0;
            sh_en_q       <= 1'b0;
            sh_flip_q     <= 1'b0;
            act_pos_x_q   <= '0;
            act_pos_y_q   <= '0;
            act_en_q      <= 1'b0;
            act_flip_q    <= 1'b0;
            mem_address_q <= '0;
            s1_hit_q      <= 1'b0;
            s1_valid_q    <= 1'b0;
            s2_hit_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            rgb_data_q    <= '0;
            hit_q         <= 1'b0;
            rgb_valid_q   <= 1'b0;
        end else begin
            sh_pos_x_q    <= sh_pos_x_d;
            sh_pos_y_q    <= sh_pos_y_d;
            sh_en_q       <= sh_en_d;
            sh_flip_q     <= sh_flip_d;
            act_pos_x_q   <= act_pos_x_d;
            act_pos_y_q   <= act_pos_y_d;
            act_en_q      <= act_en_d;
            act_flip_q    <= act_flip_d;
            mem_address_q <= mem_address_d;
            s1_hit_q      <= in_rect;
            s1_valid_q    <= pixel_valid_i;
            s2_hit_q      <= s1_hit_q;
            s2_valid_q    <= s1_valid_q;
            rgb_data_q    <= rgb_data_d;
            hit_q         <= hit_d;
            rgb_valid_q   <= s2_valid_q;
        end
    end

    assign mem_address_o = mem_address_q;
    assign rgb_data_o    = rgb_data_q;
    assign hit_o         = hit_q;
    assign rgb_valid_o   = rgb_valid_q;

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// Scoreboard bench for sprite_layer_renderer: directed pixels push expected
// ROM addresses and output words; a negedge monitor pops and compares them.
module tb_sprite_layer_renderer;

    localparam int          SW  = 32;
    localparam int          SH  = 32;
    localparam logic [23:0] KEY = 24'hFF00FF;
    localparam logic [31:0] A_PX = 32'h0, A_PY = 32'h4, A_CTRL = 32'h8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mw_i = 1'b0;
    logic [31:0] address_i = '0;
    logic [31:0] data_i = '0;
    logic [9:0]  vga_x_i = '0;
    logic [9:0]  vga_y_i = '0;
    logic        pixel_valid_i = 1'b0;
    logic [9:0]  mem_address_o;
    logic [23:0] mem_data_i = '0;
    logic [23:0] rgb_data_o;
    logic        hit_o;
    logic        rgb_valid_o;

    sprite_layer_renderer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mw_i         (mw_i),
        .address_i    (address_i),
        .data_i       (data_i),
        .vga_x_i      (vga_x_i),
        .vga_y_i      (vga_y_i),
        .pixel_valid_i(pixel_valid_i),
        .mem_address_o(mem_address_o),
        .mem_data_i   (mem_data_i),
        .rgb_data_o   (rgb_data_o),
        .hit_o        (hit_o),
        .rgb_valid_o  (rgb_valid_o)
    );

    always #5 clk = ~clk;

    // Synchronous sprite ROM: texel i is 24'hA00000 | i unless overridden.
    logic [23:0] rom [1024];
    always @(posedge clk) mem_data_i <= rom[mem_address_o];

    typedef struct { int due; logic hit; logic [23:0] rgb; } out_t;
    typedef struct { int due; logic [9:0] addr; } addr_t;
    out_t  oq[$];
    addr_t aq[$];

    int n_cmp = 0, n_fail = 0, cyc = 0, valid_cnt = 0;

    // Sprite state the stimulus expects to be active (set by hand per test).
    int cur_px = 0, cur_py = 0;
    bit cur_en = 0, cur_flip = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs; for a valid pixel, queue its expected results.
    task automatic step(int x, int y, bit v, bit w, logic [31:0] a, logic [31:0] d);
        bit inr, h;
        int dx, dy, col, ad;
        logic [23:0] tex;
        out_t o;
        addr_t e;
        vga_x_i = 10'(x); vga_y_i = 10'(y); pixel_valid_i = v;
        mw_i = w; address_i = a; data_i = d;
        if (v) begin
            inr = cur_en && x >= cur_px && x < cur_px + SW && y >= cur_py && y < cur_py + SH;
            h = 1'b0; tex = '0;
            if (inr) begin
                dx = x - cur_px; dy = y - cur_py;
                col = cur_flip ? (SW - 1 - dx) : dx;
                ad = dy * SW + col;
                tex = rom[ad];
                h = (tex != KEY);
                e.due = cyc + 1; e.addr = 10'(ad);
                aq.push_back(e);
            end
            o.due = cyc + 3; o.hit = h; o.rgb = h ? tex : 24'h0;
            oq.push_back(o);
        end
        @(posedge clk); #1;
        mw_i = 1'b0; pixel_valid_i = 1'b0;
    endtask

    task automatic pix(int x, int y);
        step(x, y, 1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        step(0, 0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: compare addresses when due and outputs whenever rgb_valid_o is up.
    always @(negedge clk) begin
        if (rgb_valid_o) valid_cnt++;
        if (aq.size() > 0 && aq[0].due == cyc) begin
            check("mem_address_o", 32'(mem_address_o), 32'(aq[0].addr));
            void'(aq.pop_front());
        end
        if (rgb_valid_o) begin
            if (oq.size() == 0) begin
                check("rgb_valid_spurious", 32'(rgb_valid_o), 32'd0);
            end else begin
                check("rgb_valid_latency", 32'(cyc), 32'(oq[0].due));
                check("hit_o", 32'(hit_o), 32'(oq[0].hit));
                check("rgb_data_o", 32'(rgb_data_o), 32'(oq[0].rgb));
                void'(oq.pop_front());
            end
        end else if (oq.size() > 0 && oq[0].due <= cyc) begin
            check("rgb_valid_missing", 32'(rgb_valid_o), 32'd1);
            void'(oq.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 24'hA00000 | 24'(i);

        // Reset state
        rst_n = 1'b0;
        @(posedge clk); #1;
        idle(2);
        check("reset_hit_o", 32'(hit_o), 32'd0);
        check("reset_rgb_data_o", 32'(rgb_data_o), 32'd0);
        check("reset_rgb_valid_o", 32'(rgb_valid_o), 32'd0);
        check("reset_mem_address_o", 32'(mem_address_o), 32'd0);
        rst_n = 1'b1;

        // Basic hit; back-to-back writes, last one wins; stray addresses ignored
        wr(A_PX, 32'd7);
        wr(A_PX, 32'hFFFF_F800 | 32'd100);
        wr(A_PY, 32'd50);
        wr(A_CTRL, 32'd1);
        wr(32'hC, 32'd0);
        wr(32'h100, 32'd0);
        pix(100, 50);                      // not yet committed: no hit
        cur_px = 100; cur_py = 50; cur_en = 1; cur_flip = 0;
        pix(0, 0);                         // frame start commits
        pix(100, 50);                      // addr 0
        pix(131, 81);                      // addr 1023
        pix(132, 50);                      // just right of sprite
        pix(99, 50);
        pix(100, 49);
        pix(131, 50);                      // addr 31
        pix(100, 82);
        idle(5);

        // Transparency and horizontal flip
        rom[0] = KEY;
        pix(100, 50);                      // addr 0, keyed out
        wr(A_CTRL, 32'd3);
        pix(110, 60);                      // flip not yet active: addr 330
        cur_flip = 1;
        pix(0, 0);
        pix(100, 50);                      // addr 31
        pix(131, 50);                      // addr 0, keyed out
        pix(110, 60);                      // addr 341
        idle(5);
        rom[0] = 24'hA00000;

        // Clipping at the right edge; 640-pixel stream on one row
        wr(A_PX, 32'd630);
        wr(A_CTRL, 32'd1);
        cur_px = 630; cur_flip = 0;
        pix(0, 0);
        idle(5);
        valid_cnt = 0;
        for (int x = 0; x < 640; x++) pix(x, 50);
        idle(5);
        check("stream_valid_count", 32'(valid_cnt), 32'd640);
        for (int x = 0; x < 4; x++) pix(x, 51);
        for (int x = 628; x < 640; x++) pix(x, 81);
        for (int x = 628; x < 640; x++) pix(x, 82);

        // Off-screen vertically: never hits
        wr(A_PY, 32'd1000);
        cur_py = 1000;
        pix(0, 0);
        for (int x = 628; x < 640; x++) pix(x, 479);
        pix(635, 50);
        idle(5);

        // Shadow commit: mid-frame write deferred to next frame start
        wr(A_PX, 32'd100);
        wr(A_PY, 32'd50);
        cur_px = 100; cur_py = 50;
        pix(0, 0);
        pix(100, 50);
        wr(A_PX, 32'd200);
        pix(100, 51);                      // still old position
        pix(200, 51);
        cur_px = 200;
        pix(0, 0);
        pix(200, 50);
        pix(100, 50);
        // Write on the frame-start edge: active takes the old shadow (200)
        step(0, 0, 1'b1, 1'b1, A_PX, 32'd300);
        pix(200, 50);
        pix(300, 50);
        cur_px = 300;
        pix(0, 0);
        pix(300, 50);
        pix(200, 50);
        idle(5);

        // Reset while hit_o is high; in-flight pixels are discarded
        pix(300, 50);
        pix(301, 50);
        pix(302, 50);
        check("pre_reset_hit_o", 32'(hit_o), 32'd1);
        rst_n = 1'b0;
        @(negedge clk); #1;
        oq.delete();
        aq.delete();
        @(posedge clk); #1;
        check("post_reset_hit_o", 32'(hit_o), 32'd0);
        check("post_reset_rgb_data_o", 32'(rgb_data_o), 32'd0);
        check("post_reset_rgb_valid_o", 32'(rgb_valid_o), 32'd0);
        check("post_reset_mem_address_o", 32'(mem_address_o), 32'd0);
        rst_n = 1'b1;
        cur_px = 0; cur_py = 0; cur_en = 0; cur_flip = 0;
        idle(4);
        pix(0, 0);
        pix(5, 5);
        pix(300, 50);
        wr(A_CTRL, 32'd1);
        pix(5, 5);                         // written but not committed
        cur_en = 1;
        pix(0, 0);                         // addr 0
        pix(5, 5);                         // addr 165
        pix(31, 31);                       // addr 1023
        pix(32, 5);
        idle(6);

        check("scoreboard_drained", 32'(oq.size()), 32'd0);
        check("address_queue_drained", 32'(aq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
